de1_soc_key_edge_pio: RTL and testbench



---
 rtl/de1_soc_key_edge_pio.sv | 120 ++++++++++++
 tb/tb_de1_soc_key_edge_pio.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/de1_soc_key_edge_pio.sv
// DE1-SoC pushbutton/switch input PIO: 2-flop sync, per-bit debounce, edge capture
// with write-1-to-clear, and a maskable level interrupt on a zero-wait Avalon-MM slave.
module de1_soc_key_edge_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_VALUE      = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic             w_wr;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_unused_wdata;

  assign w_wr           = chipselect && !write_n;
  assign w_unused_wdata = ^writedata;

  // A bit is accepted on the last cycle of an uninterrupted run of disagreement.
  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       w_set = w_accept & r_sync2;
      1:       w_set = w_accept & ~r_sync2;
      default: w_set = w_accept;
    endcase
  end

  assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_VALUE;
      r_sync2 <= IDLE_VALUE;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i] || w_accept[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= IDLE_VALUE;
    end else begin
      r_stable <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
    end
  end

  // Set is OR'd in after the clear so a same-cycle edge survives a W1C write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap <= '0;
    end else begin
      r_cap <= (r_cap & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_wr && address == 2'd2) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = r_stable;
      2'd2:    readdata[WIDTH-1:0] = r_mask;
      2'd3:    readdata[WIDTH-1:0] = r_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_de1_soc_key_edge_pio.sv
// Directed bench for de1_soc_key_edge_pio with WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture.
module tb_de1_soc_key_edge_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int total;
  int bad;

  de1_soc_key_edge_pio #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1),
    .IDLE_VALUE(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset state
    repeat (2) tick();
    rd(2'd0, 32'hF, "rst_data");
    rd(2'd1, 32'h0, "rst_dir");
    rd(2'd2, 32'h0, "rst_mask");
    rd(2'd3, 32'h0, "rst_cap");
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    repeat (20) tick();
    rd(2'd0, 32'hF, "idle_data");
    rd(2'd3, 32'h0, "idle_cap");

    // Press bit 1: DATA changes exactly 6 edges after the input change
    in_port = 4'hD;
    repeat (5) tick();
    rd(2'd0, 32'hF, "press_data_early");
    tick();
    rd(2'd0, 32'hD, "press_data");
    rd(2'd3, 32'h2, "press_cap");
    check("press_irq_unmasked", {31'd0, irq}, 32'd0);
    wr(2'd2, 32'h2);
    check("mask_irq_on", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'h2, "mask_read");
    wr(2'd2, 32'h0);
    check("mask_off_irq", {31'd0, irq}, 32'd0);
    rd(2'd3, 32'h2, "mask_off_cap_kept");
    wr(2'd2, 32'h2);
    check("mask_reenable_irq", {31'd0, irq}, 32'd1);

    // Press bit 0 as well -> capture 0x3
    in_port = 4'hC;
    repeat (6) tick();
    rd(2'd0, 32'hC, "press2_data");
    rd(2'd3, 32'h3, "press2_cap");

    // Write-1-to-clear
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h2, "w1c_bit0");
    check("w1c_bit0_irq", {31'd0, irq}, 32'd1);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, "w1c_bit1");
    check("w1c_bit1_irq", {31'd0, irq}, 32'd0);

    // Release: rising edges are not captured
    in_port = 4'hF;
    repeat (6) tick();
    rd(2'd0, 32'hF, "release_data");
    rd(2'd3, 32'h0, "release_cap");

    // Glitch of 3 cycles is rejected
    in_port = 4'hE;
    repeat (3) tick();
    in_port = 4'hF;
    repeat (10) tick();
    rd(2'd0, 32'hF, "glitch_data");
    rd(2'd3, 32'h0, "glitch_cap");
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // Set/clear collision on bit 0
    in_port = 4'hE;
    repeat (5) tick();
    rd(2'd3, 32'h0, "coll_cap_before");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h1, "coll_cap_set_wins");
    rd(2'd0, 32'hE, "coll_data");
    check("coll_irq_masked_out", {31'd0, irq}, 32'd0);

    // Reset mid-debounce (counter reaches 2)
    in_port = 4'hF;
    repeat (6) tick();
    rd(2'd0, 32'hF, "pre_rst_data");
    wr(2'd2, 32'h1);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    in_port = 4'hE;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    rd(2'd0, 32'hF, "midrst_data");
    rd(2'd2, 32'h0, "midrst_mask");
    rd(2'd3, 32'h0, "midrst_cap");
    check("midrst_irq", {31'd0, irq}, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    rd(2'd0, 32'hF, "postrst_data_early");
    rd(2'd3, 32'h0, "postrst_cap_early");
    tick();
    rd(2'd0, 32'hE, "postrst_data");
    rd(2'd3, 32'h1, "postrst_cap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
